// File: rtl/msx_fdc_ctrl.sv
// msx_fdc_ctrl: MSX slot glue for a WD1793-class FDC and disk ROM, 1..4 drives.
// Define FDC_MOTOR_TIMEOUT_EN to build the motor auto-off timer.
`timescale 1ns/1ps
module msx_fdc_ctrl #(
    parameter int NUM_DRIVES = 2,
    parameter int TMR_W = 24,
    parameter logic [TMR_W-1:0] MOTOR_TIMEOUT = 24'd3_580_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic [15:0]           addr,
    input  logic [7:0]            d_from_cpu,
    output logic [7:0]            d_to_cpu,
    input  logic                  stlsl_n,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  CS1_n,
    input  logic [7:0]            rom_q,
    input  logic [NUM_DRIVES-1:0] img_mounted,
    input  logic [31:0]           img_size,
    output logic                  fdc_io_en,
    output logic                  fdc_rd,
    output logic                  fdc_wr,
    output logic [1:0]            fdc_addr,
    input  logic [7:0]            fdc_dout,
    input  logic                  fdc_drq,
    input  logic                  fdc_intrq,
    output logic                  fdc_ready,
    output logic                  fdc_side,
    output logic [1:0]            fdc_drive,
    output logic                  motor_on
);

    logic                  regsel;
    logic                  romsel;
    logic [2:0]            ofs;
    logic                  wr_q;
    logic                  wr_ev;
    logic                  side_q;
    logic                  in_use_q;
    logic                  motor_q;
    logic [1:0]            drv_q;
    logic                  drv_valid;
    logic                  ready_sel;
    logic [NUM_DRIVES-1:0] present_q;
    logic [NUM_DRIVES-1:0] present_d;
    logic [NUM_DRIVES-1:0] changed_q;
    logic [NUM_DRIVES-1:0] changed_d;
    logic [7:0]            chg_rd;

    assign ofs    = addr[2:0];
    assign regsel = ~stlsl_n & (&addr[13:3]);
    assign romsel = (addr[15:14] == 2'b01) & ~stlsl_n & ~CS1_n & ~regsel;

    // A strobe counts once: only its first sampled cycle is an event.
    assign wr_ev = regsel & ~wr_n & ~wr_q;

    assign fdc_io_en = regsel & ~addr[2];
    assign fdc_rd    = ~rd_n;
    assign fdc_wr    = ~wr_n;
    assign fdc_addr  = addr[1:0];

    assign drv_valid = {1'b0, drv_q} < 3'(NUM_DRIVES);
    assign fdc_drive = drv_valid ? drv_q : 2'd0;
    assign fdc_side  = side_q;
    assign motor_on  = motor_q;
    assign fdc_ready = motor_q & drv_valid & ready_sel;

    // Remember the previous strobe state for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_q <= 1'b0;
        else          wr_q <= regsel & ~wr_n;
    end

    // Side, drive and in-use control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            side_q   <= 1'b0;
            drv_q    <= 2'd0;
            in_use_q <= 1'b0;
        end else if (wr_ev) begin
            if (ofs == 3'd4) side_q <= d_from_cpu[0];
            if (ofs == 3'd5) begin
                drv_q    <= d_from_cpu[1:0];
                in_use_q <= d_from_cpu[6];
            end
        end
    end

    // Next image state: W1C clear first so a same-cycle mount wins.
    always_comb begin
        present_d = present_q;
        changed_d = changed_q;
        if (wr_ev && ofs == 3'd6)
            changed_d = changed_q & ~d_from_cpu[NUM_DRIVES-1:0];
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (img_mounted[i]) begin
                present_d[i] = |img_size;
                changed_d[i] = 1'b1;
            end
        end
    end

    // Per-drive presence and disk-change latches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            present_q <= '0;
            changed_q <= '0;
        end else begin
            present_q <= present_d;
            changed_q <= changed_d;
        end
    end

`ifdef FDC_MOTOR_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q;
    logic             fdc_wr_ev;
    logic             unused_ok;

    assign fdc_wr_ev = wr_ev & ~addr[2];
    assign unused_ok = ^{d_from_cpu[5:2]};

    // Motor hold timer: explicit writes and FDC accesses beat tick decrements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q   <= '0;
            motor_q <= 1'b0;
        end else if (wr_ev && ofs == 3'd5) begin
            tmr_q   <= d_from_cpu[7] ? MOTOR_TIMEOUT : '0;
            motor_q <= d_from_cpu[7];
        end else if (fdc_wr_ev && motor_q) begin
            tmr_q <= MOTOR_TIMEOUT;
        end else if (clk_en && tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
            if (tmr_q == TMR_W'(1)) motor_q <= 1'b0;
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{d_from_cpu[5:2], clk_en, MOTOR_TIMEOUT};

    // Motor follows the last requested state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    motor_q <= 1'b0;
        else if (wr_ev && ofs == 3'd5)   motor_q <= d_from_cpu[7];
    end
`endif

    // READY source for the selected drive.
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < NUM_DRIVES; i++)
            if (drv_q == 2'(i)) ready_sel = present_q[i];
    end

    // Disk-change status with unused drive bits read as ones.
    always_comb begin
        chg_rd = 8'hFF;
        chg_rd[NUM_DRIVES-1:0] = changed_q;
    end

    // CPU read mux: ROM first, then the register window.
    always_comb begin
        d_to_cpu = 8'hFF;
        if (romsel) begin
            d_to_cpu = rom_q;
        end else if (regsel) begin
            case (ofs)
                3'd0, 3'd1, 3'd2, 3'd3:
                    if (!rd_n) d_to_cpu = fdc_dout;
                3'd4: d_to_cpu = {7'h7F, ~side_q};
                3'd5: d_to_cpu = {motor_q, in_use_q, 4'hF, drv_q};
                3'd6: d_to_cpu = chg_rd;
                default: d_to_cpu = {~fdc_drq, ~fdc_intrq, 6'h3F};
            endcase
        end
    end

endmodule

// File: tb/tb_msx_fdc_ctrl.sv
// tb_msx_fdc_ctrl: randomized bench with a behavioural model of the glue.
// Honours FDC_MOTOR_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_msx_fdc_ctrl;

    localparam int ND = 2;
    localparam int TO = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en;
    logic [15:0]   addr;
    logic [7:0]    d_from_cpu;
    logic [7:0]    d_to_cpu;
    logic          stlsl_n;
    logic          wr_n;
    logic          rd_n;
    logic          CS1_n;
    logic [7:0]    rom_q;
    logic [ND-1:0] img_mounted;
    logic [31:0]   img_size;
    logic          fdc_io_en;
    logic          fdc_rd;
    logic          fdc_wr;
    logic [1:0]    fdc_addr;
    logic [7:0]    fdc_dout;
    logic          fdc_drq;
    logic          fdc_intrq;
    logic          fdc_ready;
    logic          fdc_side;
    logic [1:0]    fdc_drive;
    logic          motor_on;

    int n_chk = 0;
    int n_fail = 0;
    int en_mode;

    // behavioural model state
    logic          m_side;
    logic [1:0]    m_drv;
    logic          m_inuse;
    logic          m_motor;
    int            m_tmr;
    logic [ND-1:0] m_pres;
    logic [ND-1:0] m_chg;
    logic          wr_ev;
    logic [2:0]    wr_off;
    logic [7:0]    wr_dat;

    msx_fdc_ctrl #(
        .NUM_DRIVES(ND),
        .TMR_W(24),
        .MOTOR_TIMEOUT(24'd5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk_en(clk_en),
        .addr(addr),
        .d_from_cpu(d_from_cpu),
        .d_to_cpu(d_to_cpu),
        .stlsl_n(stlsl_n),
        .wr_n(wr_n),
        .rd_n(rd_n),
        .CS1_n(CS1_n),
        .rom_q(rom_q),
        .img_mounted(img_mounted),
        .img_size(img_size),
        .fdc_io_en(fdc_io_en),
        .fdc_rd(fdc_rd),
        .fdc_wr(fdc_wr),
        .fdc_addr(fdc_addr),
        .fdc_dout(fdc_dout),
        .fdc_drq(fdc_drq),
        .fdc_intrq(fdc_intrq),
        .fdc_ready(fdc_ready),
        .fdc_side(fdc_side),
        .fdc_drive(fdc_drive),
        .motor_on(motor_on)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_side  = 1'b0;
        m_drv   = 2'd0;
        m_inuse = 1'b0;
        m_motor = 1'b0;
        m_tmr   = 0;
        m_pres  = '0;
        m_chg   = '0;
        wr_ev   = 1'b0;
    endtask

    function automatic logic exp_ready();
        return m_motor && (int'(m_drv) < ND) && m_pres[m_drv[0]];
    endfunction

    function automatic logic [7:0] exp_rd(input logic [2:0] o);
        case (o)
            3'd4:    return {7'h7F, ~m_side};
            3'd5:    return {m_motor, m_inuse, 4'hF, m_drv};
            3'd6:    return {6'h3F, m_chg};
            3'd7:    return {~fdc_drq, ~fdc_intrq, 6'h3F};
            default: return fdc_dout;
        endcase
    endfunction

    // one clock: advance the model by the rules for the edge just seen
    task automatic cyc();
        @(posedge clk);
        if (wr_ev) begin
            case (wr_off)
                3'd4: m_side = wr_dat[0];
                3'd5: begin
                    m_drv   = wr_dat[1:0];
                    m_inuse = wr_dat[6];
                end
                3'd6: m_chg = m_chg & ~wr_dat[ND-1:0];
                default: ;
            endcase
        end
`ifdef FDC_MOTOR_TIMEOUT_EN
        if (wr_ev && wr_off == 3'd5) begin
            m_motor = wr_dat[7];
            m_tmr   = wr_dat[7] ? TO : 0;
        end else if (wr_ev && wr_off < 3'd4 && m_motor) begin
            m_tmr = TO;
        end else if (clk_en && m_tmr > 0) begin
            m_tmr--;
            if (m_tmr == 0) m_motor = 1'b0;
        end
`else
        if (wr_ev && wr_off == 3'd5) m_motor = wr_dat[7];
`endif
        for (int i = 0; i < ND; i++) begin
            if (img_mounted[i]) begin
                m_pres[i] = (img_size != 0);
                m_chg[i]  = 1'b1;
            end
        end
        wr_ev = 1'b0;
        @(negedge clk);
        img_mounted = '0;
        clk_en = (en_mode == 1) ? 1'b1 :
                 (en_mode == 2) ? 1'b0 : 1'($urandom);
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [7:0] d,
                          input int hold, input int mcyc,
                          input logic [ND-1:0] mmask);
        cyc();
        addr       = {2'($urandom), 11'h7FF, off};
        d_from_cpu = d;
        stlsl_n    = 1'b0;
        wr_n       = 1'b0;
        wr_ev      = 1'b1;
        wr_off     = off;
        wr_dat     = d;
        for (int i = 0; i < hold; i++) begin
            if (i == mcyc) img_mounted = mmask;
            cyc();
        end
        wr_n    = 1'b1;
        stlsl_n = 1'b1;
        addr    = '0;
    endtask

    task automatic mount(input logic [ND-1:0] m, input logic [31:0] sz);
        img_mounted = m;
        img_size    = sz;
        cyc();
    endtask

    task automatic rd_reg(input logic [2:0] o, output logic [7:0] v);
        addr    = {2'b00, 11'h7FF, o};
        stlsl_n = 1'b0;
        rd_n    = 1'b0;
        CS1_n   = 1'b1;
        #0.5;
        v       = d_to_cpu;
        stlsl_n = 1'b1;
        rd_n    = 1'b1;
        addr    = '0;
    endtask

    task automatic check_all(input string tg);
        logic [2:0] o;
        chk({tg, "_rdy"}, 32'(fdc_ready), 32'(exp_ready()));
        chk({tg, "_side"}, 32'(fdc_side), 32'(m_side));
        chk({tg, "_drv"}, 32'(fdc_drive),
            32'((int'(m_drv) < ND) ? m_drv : 2'd0));
        chk({tg, "_mot"}, 32'(motor_on), 32'(m_motor));
        fdc_drq   = 1'($urandom);
        fdc_intrq = 1'($urandom);
        fdc_dout  = 8'($urandom);
        rom_q     = 8'($urandom);
        stlsl_n   = 1'b0;
        rd_n      = 1'b0;
        CS1_n     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            o    = 3'(i);
            addr = {2'($urandom), 11'h7FF, o};
            #0.5;
            chk({tg, "_rd"}, 32'(d_to_cpu), 32'(exp_rd(o)));
            chk({tg, "_ioen"}, 32'(fdc_io_en), 32'(i < 4));
            chk({tg, "_fa"}, 32'(fdc_addr), 32'(o[1:0]));
        end
        chk({tg, "_frd"}, 32'(fdc_rd), 32'd1);
        addr = 16'h4000 | 16'($urandom_range(0, 16'h3FF7));
        #0.5;
        chk({tg, "_rom"}, 32'(d_to_cpu), 32'(rom_q));
        stlsl_n = 1'b1;
        #0.5;
        chk({tg, "_idle"}, 32'(d_to_cpu), 32'hFF);
        rd_n      = 1'b1;
        CS1_n     = 1'b1;
        addr      = '0;
        fdc_drq   = 1'b0;
        fdc_intrq = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int n;
        int r;
        reset_n     = 1'b0;
        clk_en      = 1'b0;
        en_mode     = 2;
        addr        = '0;
        d_from_cpu  = '0;
        stlsl_n     = 1'b1;
        wr_n        = 1'b1;
        rd_n        = 1'b1;
        CS1_n       = 1'b1;
        rom_q       = 8'h5A;
        img_mounted = '0;
        img_size    = '0;
        fdc_dout    = '0;
        fdc_drq     = 1'b0;
        fdc_intrq   = 1'b0;
        wr_off      = '0;
        wr_dat      = '0;
        model_reset();

        #1;
        chk("rst_rdy", 32'(fdc_ready), 32'd0);
        chk("rst_side", 32'(fdc_side), 32'd0);
        chk("rst_drv", 32'(fdc_drive), 32'd0);
        chk("rst_dout", 32'(d_to_cpu), 32'hFF);
        @(negedge clk);
        reset_n = 1'b1;
        check_all("rst");
        rd_reg(3'd4, v); chk("rst_o4", 32'(v), 32'hFF);
        rd_reg(3'd5, v); chk("rst_o5", 32'(v), 32'h3C);
        rd_reg(3'd6, v); chk("rst_o6", 32'(v), 32'hFC);
        rd_reg(3'd7, v); chk("rst_o7", 32'(v), 32'hFF);

        // mount drive 1, select it with motor on
        mount(2'b10, 32'd737280);
        bus_wr(3'd5, 8'h81, 1, -1, '0);
        rd_reg(3'd6, v); chk("mnt_o6", 32'(v), 32'hFE);
        chk("mnt_rdy", 32'(fdc_ready), 32'd1);
        chk("mnt_drv", 32'(fdc_drive), 32'd1);
        check_all("mnt");
        bus_wr(3'd6, 8'h02, 1, -1, '0);
        rd_reg(3'd6, v); chk("w1c_o6", 32'(v), 32'hFC);

        // out-of-range drive
        bus_wr(3'd5, 8'h83, 1, -1, '0);
        chk("bad_rdy", 32'(fdc_ready), 32'd0);
        chk("bad_drv", 32'(fdc_drive), 32'd0);
        rd_reg(3'd5, v); chk("bad_o5", 32'(v), 32'hBF);
        check_all("bad");

        // long strobe: one clear, later mount survives
        mount(2'b11, 32'd1000);
        bus_wr(3'd6, 8'h03, 10, 4, 2'b01);
        rd_reg(3'd6, v); chk("hold_o6", 32'(v), 32'hFD);
        bus_wr(3'd6, 8'h01, 3, 0, 2'b01);
        rd_reg(3'd6, v); chk("setwin_o6", 32'(v), 32'hFD);
        bus_wr(3'd4, 8'h01, 2, -1, '0);
        rd_reg(3'd4, v); chk("side_o4", 32'(v), 32'hFE);
        check_all("side");

        // motor hold time
        en_mode = 1;
        clk_en  = 1'b1;
        bus_wr(3'd5, 8'h80, 1, -1, '0);
        n = 0;
        while (motor_on && n < 20) begin
            n++;
            cyc();
            chk("mot_run", 32'(motor_on), 32'(m_motor));
        end
`ifdef FDC_MOTOR_TIMEOUT_EN
        chk("mot_ticks", 32'(n), 32'd5);
`else
        chk("mot_ticks", 32'(n), 32'd20);
`endif
        bus_wr(3'd5, 8'h80, 1, -1, '0);
        cyc();
        cyc();
        bus_wr(3'd0, 8'h00, 1, -1, '0);
        n = 0;
        while (motor_on && n < 20) begin
            n++;
            cyc();
            chk("mot_ext", 32'(motor_on), 32'(m_motor));
        end
`ifdef FDC_MOTOR_TIMEOUT_EN
        chk("mot_ext_ticks", 32'(n), 32'd5);
`else
        chk("mot_ext_ticks", 32'(n), 32'd20);
`endif

        // asynchronous reset mid-access
        en_mode = 2;
        clk_en  = 1'b0;
        bus_wr(3'd5, 8'h81, 1, -1, '0);
        bus_wr(3'd4, 8'h01, 1, -1, '0);
        chk("pre_rdy", 32'(fdc_ready), 32'd1);
        chk("pre_drv", 32'(fdc_drive), 32'd1);
        chk("pre_side", 32'(fdc_side), 32'd1);
        addr       = {2'b00, 11'h7FF, 3'd4};
        stlsl_n    = 1'b0;
        wr_n       = 1'b0;
        d_from_cpu = 8'h00;
        #3 reset_n = 1'b0;
        #1;
        chk("ar_rdy", 32'(fdc_ready), 32'd0);
        chk("ar_side", 32'(fdc_side), 32'd0);
        chk("ar_drv", 32'(fdc_drive), 32'd0);
        chk("ar_mot", 32'(motor_on), 32'd0);
        wr_n    = 1'b1;
        stlsl_n = 1'b1;
        rd_reg(3'd5, v); chk("ar_o5", 32'(v), 32'h3C);
        rd_reg(3'd6, v); chk("ar_o6", 32'(v), 32'hFC);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all("post_rst");

        // randomized traffic
        en_mode = 0;
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 7));
            img_size = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            if (r < 4) begin
                bus_wr(($urandom_range(0, 3) == 0) ? 3'($urandom) :
                       3'(4 + $urandom_range(0, 2)),
                       8'($urandom), int'($urandom_range(1, 4)),
                       int'($urandom_range(0, 4)) - 1, 2'($urandom));
            end else if (r < 6) begin
                mount(2'($urandom_range(1, 3)), img_size);
            end else begin
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) cyc();
            end
            check_all("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
